// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
// Holds funct3 encodings, the FSM state type and lane helpers.
package dmem_lsu_pkg;

  localparam logic [31:0] ZERO = 32'h0000_0000;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  // Byte enables for an access of size sz at byte offset lo.
  function automatic logic [3:0] lane_be(
    input logic [1:0] sz,
    input logic [1:0] lo
  );
    logic [3:0] be;
    be = 4'b0000;
    unique case (1'b1)
      (sz == SZ_B): be = 4'b0001 << lo;
      (sz == SZ_H): be = lo[1] ? 4'b1100 : 4'b0011;
      (sz == SZ_W): be = 4'b1111;
      default:      be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_lsu_load_extend.sv
// Load data extraction: picks the byte/halfword lane and extends it.
// Ports: i_funct3, i_addr (byte offset), i_word (raw RAM word), o_data.
module load_extend
  import dmem_lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  w_b;
  logic [15:0] w_h;

  assign w_b = i_word[{i_addr, 3'b000} +: 8];
  assign w_h = i_addr[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = ZERO;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_b[7]}}, w_b};
      F3_LBU:  o_data = {24'h0, w_b};
      F3_LH:   o_data = {{16{w_h[15]}}, w_h};
      F3_LHU:  o_data = {16'h0, w_h};
      F3_LW:   o_data = i_word;
      default: o_data = ZERO;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the MEM stage and a synchronous data RAM.
// Ports: req_* (valid/ready request), resp_* (1-cycle pulse), mem_* (RAM).
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (DATA_W != 32) begin : g_bad_dw
    $error("dmem_lsu: DATA_W must be 32");
  end
  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("dmem_lsu: MEM_LAT must be 1..4");
  end

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  lsu_state_t r_state;
  lsu_state_t w_next;

  logic              r_write;
  logic [2:0]        r_f3;
  logic [1:0]        r_lo;
  logic [2:0]        r_cnt;

  logic              r_resp_valid;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-3:0] r_mem_addr;
  logic [3:0]        r_mem_be;
  logic [DATA_W-1:0] r_mem_wdata;

  logic        w_accept;
  logic        w_f3_ok;
  logic        w_mis;
  logic        w_bad;
  logic [1:0]  w_sz;
  logic [31:0] w_lane_wd;
  logic [31:0] w_ext;

  assign req_ready = rst_n && (r_state == IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_sz      = req_funct3[1:0];

  // Unsigned loads have no store counterpart.
  always_comb begin
    w_f3_ok = 1'b0;
    case (req_funct3)
      F3_LB, F3_LH, F3_LW: w_f3_ok = 1'b1;
      F3_LBU, F3_LHU:      w_f3_ok = !req_write;
      default:             w_f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_mis = 1'b0;
    unique case (1'b1)
      (w_sz == SZ_H): w_mis = req_addr[0];
      (w_sz == SZ_W): w_mis = |req_addr[1:0];
      default:        w_mis = 1'b0;
    endcase
  end

  assign w_bad = !w_f3_ok || w_mis;

  // Replicate store data so any lane the enables pick holds it.
  always_comb begin
    w_lane_wd = ZERO;
    unique case (1'b1)
      (w_sz == SZ_B): w_lane_wd = {4{req_wdata[7:0]}};
      (w_sz == SZ_H): w_lane_wd = {2{req_wdata[15:0]}};
      default:        w_lane_wd = req_wdata[31:0];
    endcase
  end

  load_extend u_ext (
    .i_funct3 (r_f3),
    .i_addr   (r_lo),
    .i_word   (mem_rdata[31:0]),
    .o_data   (w_ext)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_next = w_bad ? RESP : ISSUE;
      end
      ISSUE: w_next = r_write ? RESP : WAIT;
      WAIT: begin
        if (r_cnt == 3'd1) w_next = RESP;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_write      <= 1'b0;
      r_f3         <= 3'b000;
      r_lo         <= 2'b00;
      r_cnt        <= 3'd0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_be     <= 4'b0000;
      r_mem_wdata  <= '0;
    end else begin
      r_state      <= w_next;
      r_resp_valid <= (w_next == RESP);
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_be     <= 4'b0000;
      r_mem_wdata  <= '0;
      if (w_accept) begin
        r_write <= req_write;
        r_f3    <= req_funct3;
        r_lo    <= req_addr[1:0];
        if (w_bad) begin
          r_resp_err <= 1'b1;
        end else begin
          r_mem_en    <= 1'b1;
          r_mem_we    <= req_write;
          r_mem_addr  <= req_addr[ADDR_W-1:2];
          r_mem_be    <= lane_be(w_sz, req_addr[1:0]);
          r_mem_wdata <= req_write ? w_lane_wd : ZERO;
        end
      end
      if (r_state == ISSUE && !r_write) begin
        r_cnt <= LAT;
      end
      if (r_state == WAIT) begin
        r_cnt <= r_cnt - 3'd1;
        if (r_cnt == 3'd1) r_resp_rdata <= w_ext;
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_be     = r_mem_be;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: two instances (MEM_LAT 1 and 3) share stimulus,
// each with its own RAM; results are compared to a byte-array model.
module tb_dmem_lsu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;

  logic [1:0]  rdy, rv, re, men, mwe;
  logic [31:0] rd [2];
  logic [31:0] mwd [2];
  logic [31:0] mrd [2];
  logic [29:0] ma [2];
  logic [3:0]  mbe [2];

  logic [29:0] s_ma [2];
  logic [3:0]  s_be [2];
  logic [31:0] s_wd [2];
  logic        s_we [2];

  int n_cmp = 0;
  int n_err = 0;

  byte unsigned mdl [64];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] ram [16] = '{default: 32'h0};
    logic [31:0] pipe [4] = '{default: 32'h0};

    dmem_lsu #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (rdy[g]),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (rv[g]),
      .resp_rdata (rd[g]),
      .resp_err   (re[g]),
      .mem_en     (men[g]),
      .mem_we     (mwe[g]),
      .mem_addr   (ma[g]),
      .mem_be     (mbe[g]),
      .mem_wdata  (mwd[g]),
      .mem_rdata  (mrd[g])
    );

    always @(posedge clk) begin
      if (men[g] && mwe[g]) begin
        for (int b = 0; b < 4; b++)
          if (mbe[g][b]) ram[ma[g][3:0]][8*b +: 8] <= mwd[g][8*b +: 8];
      end
      pipe[0] <= ram[ma[g][3:0]];
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end

    assign mrd[g] = pipe[LAT-1];
  end

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic bit m_bad(input bit w, input bit [2:0] f3,
                               input bit [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (w && f3 >= 3'd4) return 1'b1;
    if (f3[1:0] == 2'd1 && a[0]) return 1'b1;
    if (f3[1:0] == 2'd2 && a[1:0] != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit [31:0] m_load(input bit [2:0] f3,
                                       input bit [31:0] a);
    int n;
    bit [31:0] v;
    n = 1 << f3[1:0];
    v = 0;
    for (int i = 0; i < n; i++)
      v = v | (32'(mdl[(int'(a[5:0]) + i) % 64]) << (8 * i));
    if (!f3[2] && n < 4 && v[8*n-1])
      v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic m_store(input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd);
    int n;
    n = 1 << f3[1:0];
    for (int i = 0; i < n; i++)
      mdl[(int'(a[5:0]) + i) % 64] = 8'(wd >> (8 * i));
  endtask

  task automatic do_req(input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic e_err, input logic [31:0] e_rd,
                        input string nm);
    int n_rv [2];
    int n_en [2];
    int n_junk [2];
    int lat [2];
    logic [31:0] g_rd [2];
    logic g_err [2];
    int e_lat;
    @(negedge clk);
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    for (int g = 0; g < 2; g++) begin
      n_rv[g] = 0; n_en[g] = 0; n_junk[g] = 0; lat[g] = 0;
      g_rd[g] = 32'h0; g_err[g] = 1'b0;
      chk({nm, " ready"}, 32'(rdy[g]), 32'd1);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (rv[g]) begin
          n_rv[g]++; lat[g] = k; g_rd[g] = rd[g]; g_err[g] = re[g];
        end else if (rd[g] != 32'h0 || re[g]) begin
          n_junk[g]++;
        end
        if (men[g]) n_en[g]++;
        if (k == 1) begin
          s_ma[g] = ma[g]; s_be[g] = mbe[g];
          s_wd[g] = mwd[g]; s_we[g] = mwe[g];
        end
      end
      if (k == 1) req_valid = 1'b0;
    end
    for (int g = 0; g < 2; g++) begin
      e_lat = e_err ? 1 : (w ? 2 : lat_of(g) + 2);
      chk({nm, " nresp"}, 32'(n_rv[g]), 32'd1);
      chk({nm, " latency"}, 32'(lat[g]), 32'(e_lat));
      chk({nm, " err"}, 32'(g_err[g]), 32'(e_err));
      chk({nm, " rdata"}, g_rd[g], e_rd);
      chk({nm, " mem_en count"}, 32'(n_en[g]), e_err ? 32'd0 : 32'd1);
      chk({nm, " idle outputs"}, 32'(n_junk[g]), 32'd0);
    end
    if (!e_err && w) m_store(f3, a, wd);
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
    logic        cm;
    logic [29:0] ma;
    logic [3:0]  be;
    logic [31:0] mwd;
  } vec_t;

  vec_t tv [20];

  initial begin
    int bb_en [2];
    int bb_rdy [2];
    int bb_lat [2];
    logic [31:0] bb_rd [2];
    int rs_rv [2];
    int rs_en [2];
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic        bad;

    for (int i = 0; i < 64; i++) mdl[i] = 8'h00;

    tv[0]  = '{1'b1, 3'd2, 32'h000, 32'h80F17F22, 1'b0, 32'h0,
               1'b1, 30'h0, 4'hF, 32'h80F17F22};
    tv[1]  = '{1'b0, 3'd0, 32'h002, 32'h0, 1'b0, 32'hFFFFFFF1,
               1'b0, 30'h0, 4'h0, 32'h0};
    tv[2]  = '{1'b0, 3'd4, 32'h002, 32'h0, 1'b0, 32'h000000F1,
               1'b0, 30'h0, 4'h0, 32'h0};
    tv[3]  = '{1'b0, 3'd1, 32'h002, 32'h0, 1'b0, 32'hFFFF80F1,
               1'b0, 30'h0, 4'h0, 32'h0};
    tv[4]  = '{1'b0, 3'd2, 32'h000, 32'h0, 1'b0, 32'h80F17F22,
               1'b0, 30'h0, 4'h0, 32'h0};
    tv[5]  = '{1'b0, 3'd5, 32'h000, 32'h0, 1'b0, 32'h00007F22,
               1'b0, 30'h0, 4'h0, 32'h0};
    tv[6]  = '{1'b0, 3'd0, 32'h001, 32'h0, 1'b0, 32'h0000007F,
               1'b0, 30'h0, 4'h0, 32'h0};
    tv[7]  = '{1'b1, 3'd0, 32'h103, 32'h000000A5, 1'b0, 32'h0,
               1'b1, 30'h40, 4'b1000, 32'hA5A5A5A5};
    tv[8]  = '{1'b0, 3'd2, 32'h100, 32'h0, 1'b0, 32'hA5F17F22,
               1'b0, 30'h0, 4'h0, 32'h0};
    tv[9]  = '{1'b0, 3'd2, 32'h102, 32'h0, 1'b1, 32'h0,
               1'b0, 30'h0, 4'h0, 32'h0};
    tv[10] = '{1'b1, 3'd1, 32'h101, 32'h1234, 1'b1, 32'h0,
               1'b0, 30'h0, 4'h0, 32'h0};
    tv[11] = '{1'b0, 3'd3, 32'h000, 32'h0, 1'b1, 32'h0,
               1'b0, 30'h0, 4'h0, 32'h0};
    tv[12] = '{1'b1, 3'd4, 32'h000, 32'h55, 1'b1, 32'h0,
               1'b0, 30'h0, 4'h0, 32'h0};
    tv[13] = '{1'b0, 3'd6, 32'h000, 32'h0, 1'b1, 32'h0,
               1'b0, 30'h0, 4'h0, 32'h0};
    tv[14] = '{1'b1, 3'd7, 32'h004, 32'h77, 1'b1, 32'h0,
               1'b0, 30'h0, 4'h0, 32'h0};
    tv[15] = '{1'b1, 3'd1, 32'h006, 32'h0000BEEF, 1'b0, 32'h0,
               1'b1, 30'h1, 4'b1100, 32'hBEEFBEEF};
    tv[16] = '{1'b0, 3'd5, 32'h006, 32'h0, 1'b0, 32'h0000BEEF,
               1'b0, 30'h0, 4'h0, 32'h0};
    tv[17] = '{1'b0, 3'd1, 32'h006, 32'h0, 1'b0, 32'hFFFFBEEF,
               1'b0, 30'h0, 4'h0, 32'h0};
    tv[18] = '{1'b0, 3'd0, 32'h007, 32'h0, 1'b0, 32'hFFFFFFBE,
               1'b0, 30'h0, 4'h0, 32'h0};
    tv[19] = '{1'b0, 3'd4, 32'h004, 32'h0, 1'b0, 32'h00000000,
               1'b0, 30'h0, 4'h0, 32'h0};

    // Reset state.
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("reset ready", 32'(rdy[g]), 32'd0);
      chk("reset resp_valid", 32'(rv[g]), 32'd0);
      chk("reset mem_en", 32'(men[g]), 32'd0);
      chk("reset resp_rdata", rd[g], 32'h0);
      chk("reset mem_be", 32'(mbe[g]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 2; g++)
      chk("post-reset ready", 32'(rdy[g]), 32'd1);

    // Directed vectors.
    for (int i = 0; i < 20; i++) begin
      do_req(tv[i].w, tv[i].f3, tv[i].a, tv[i].wd,
             tv[i].err, tv[i].rd, $sformatf("vec%0d", i));
      if (tv[i].cm) begin
        for (int g = 0; g < 2; g++) begin
          chk($sformatf("vec%0d mem_addr", i), 32'(s_ma[g]), 32'(tv[i].ma));
          chk($sformatf("vec%0d mem_be", i), 32'(s_be[g]), 32'(tv[i].be));
          chk($sformatf("vec%0d mem_wdata", i), s_wd[g], tv[i].mwd);
          chk($sformatf("vec%0d mem_we", i), 32'(s_we[g]), 32'd1);
        end
      end
    end

    // Reset in the middle of a load.
    @(negedge clk);
    req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0;
    req_valid = 1'b1;
    for (int g = 0; g < 2; g++) begin
      chk("rst-mid ready", 32'(rdy[g]), 32'd1);
      rs_rv[g] = 0; rs_en[g] = 0;
    end
    @(negedge clk);
    req_valid = 1'b0;
    for (int g = 0; g < 2; g++)
      chk("rst-mid issue", 32'(men[g]), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst-mid mem_en", 32'(men[g]), 32'd0);
      chk("rst-mid resp_valid", 32'(rv[g]), 32'd0);
      chk("rst-mid ready low", 32'(rdy[g]), 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (rv[g]) rs_rv[g]++;
        if (men[g]) rs_en[g]++;
        if (k == 0) chk("rst-mid ready back", 32'(rdy[g]), 32'd1);
      end
    end
    for (int g = 0; g < 2; g++) begin
      chk("rst-mid no resp", 32'(rs_rv[g]), 32'd0);
      chk("rst-mid no mem_en", 32'(rs_en[g]), 32'd0);
    end

    // Back-to-back: valid held high across sw then lw.
    @(negedge clk);
    req_write = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h24; req_wdata = 32'h1234_5678;
    req_valid = 1'b1;
    for (int g = 0; g < 2; g++) begin
      chk("b2b accept sw", 32'(rdy[g]), 32'd1);
      bb_en[g] = 0; bb_rdy[g] = 0; bb_lat[g] = 0; bb_rd[g] = 32'h0;
    end
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("b2b issue ready", 32'(rdy[g]), 32'd0);
      if (men[g]) bb_en[g]++;
    end
    req_write = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("b2b resp ready", 32'(rdy[g]), 32'd0);
      chk("b2b sw resp", 32'(rv[g]), 32'd1);
      if (men[g]) bb_en[g]++;
    end
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("b2b accept lw", 32'(rdy[g]), 32'd1);
      if (men[g]) bb_en[g]++;
    end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (men[g]) bb_en[g]++;
        if (rdy[g] && k <= lat_of(g) + 2) bb_rdy[g]++;
        if (rv[g]) begin bb_lat[g] = k; bb_rd[g] = rd[g]; end
      end
      if (k == 1) req_valid = 1'b0;
    end
    for (int g = 0; g < 2; g++) begin
      chk("b2b mem_en count", 32'(bb_en[g]), 32'd2);
      chk("b2b ready while busy", 32'(bb_rdy[g]), 32'd0);
      chk("b2b lw latency", 32'(bb_lat[g]), 32'(lat_of(g) + 2));
      chk("b2b lw rdata", bb_rd[g], 32'h1234_5678);
      chk("b2b ready after", 32'(rdy[g]), 32'd1);
    end
    m_store(3'd2, 32'h24, 32'h1234_5678);

    // Randomised traffic against the byte-array model.
    for (int i = 0; i < 200; i++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      wd = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      bad = m_bad(w, f3, a);
      do_req(w, f3, a, wd, bad, (bad || w) ? 32'h0 : m_load(f3, a),
             $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
